// File: rtl/debug_load_ctrl.sv
// debug_load_ctrl: decodes words from tx_buffer into program loads and CPU run/step/reset controls
module debug_load_ctrl #(
    parameter int                    WORD_WIDTH      = 32,
    parameter int                    IMEM_ADDR_WIDTH = 8,
    parameter logic [WORD_WIDTH-1:0] CMD_LOAD        = 32'h0000_0001,
    parameter logic [WORD_WIDTH-1:0] CMD_RUN         = 32'h0000_0002,
    parameter logic [WORD_WIDTH-1:0] CMD_STEP        = 32'h0000_0003,
    parameter logic [WORD_WIDTH-1:0] CMD_CPU_RST     = 32'h0000_0004
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [WORD_WIDTH-1:0]      i_word,
    input  logic                       i_word_valid,
    input  logic                       i_cpu_halt,
    output logic                       o_imem_we,
    output logic [IMEM_ADDR_WIDTH-1:0] o_imem_addr,
    output logic [WORD_WIDTH-1:0]      o_imem_data,
    output logic                       o_cpu_enable,
    output logic                       o_cpu_reset,
    output logic                       o_load_done,
    output logic                       o_run_done,
    output logic                       o_err,
    output logic                       o_busy
);
    typedef enum logic [2:0] {IDLE, LOAD_CNT, LOAD_DATA, RUN, STEP} state_t;
    localparam logic [WORD_WIDTH-1:0]      MAX_N = WORD_WIDTH'(2 ** IMEM_ADDR_WIDTH);
    localparam logic [IMEM_ADDR_WIDTH:0]   ONE   = (IMEM_ADDR_WIDTH + 1)'(1);
    state_t                     state, state_nxt;
    logic [IMEM_ADDR_WIDTH:0]   remain, remain_nxt;
    logic [IMEM_ADDR_WIDTH-1:0] addr, addr_nxt, imem_addr_nxt;
    logic [WORD_WIDTH-1:0]      imem_data_nxt;
    logic we_nxt, en_nxt, crst_nxt, ld_nxt, rd_nxt, err_nxt;
    always_comb begin
        state_nxt     = state;
        remain_nxt    = remain;
        addr_nxt      = addr;
        imem_addr_nxt = o_imem_addr;
        imem_data_nxt = o_imem_data;
        we_nxt        = 1'b0;
        en_nxt        = 1'b0;
        crst_nxt      = 1'b0;
        ld_nxt        = 1'b0;
        rd_nxt        = 1'b0;
        err_nxt       = 1'b0;
        case (state)
            IDLE: if (i_word_valid) begin
                if (i_word == CMD_LOAD) state_nxt = LOAD_CNT;
                else if (i_word == CMD_RUN) begin
                    state_nxt = RUN;
                    en_nxt    = 1'b1;
                end else if (i_word == CMD_STEP) begin
                    state_nxt = STEP;
                    en_nxt    = 1'b1;
                end else if (i_word == CMD_CPU_RST) crst_nxt = 1'b1;
                else err_nxt = 1'b1;
            end
            LOAD_CNT: if (i_word_valid) begin
                if (i_word == '0) begin
                    ld_nxt    = 1'b1;
                    state_nxt = IDLE;
                end else if (i_word > MAX_N) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    remain_nxt = i_word[IMEM_ADDR_WIDTH:0];
                    addr_nxt   = '0;
                    state_nxt  = LOAD_DATA;
                end
            end
            LOAD_DATA: if (i_word_valid) begin
                we_nxt        = 1'b1;
                imem_data_nxt = i_word;
                imem_addr_nxt = addr;
                addr_nxt      = addr + 1'b1;
                remain_nxt    = remain - 1'b1;
                if (remain == ONE) begin
                    ld_nxt    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                err_nxt = i_word_valid;
                if (i_cpu_halt) begin
                    rd_nxt    = 1'b1;
                    state_nxt = IDLE;
                end else en_nxt = 1'b1;
            end
            STEP: begin
                err_nxt   = i_word_valid;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state        <= IDLE;
            remain       <= '0;
            addr         <= '0;
            o_imem_we    <= 1'b0;
            o_imem_addr  <= '0;
            o_imem_data  <= '0;
            o_cpu_enable <= 1'b0;
            o_cpu_reset  <= 1'b0;
            o_load_done  <= 1'b0;
            o_run_done   <= 1'b0;
            o_err        <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            state        <= state_nxt;
            remain       <= remain_nxt;
            addr         <= addr_nxt;
            o_imem_we    <= we_nxt;
            o_imem_addr  <= imem_addr_nxt;
            o_imem_data  <= imem_data_nxt;
            o_cpu_enable <= en_nxt;
            o_cpu_reset  <= crst_nxt;
            o_load_done  <= ld_nxt;
            o_run_done   <= rd_nxt;
            o_err        <= err_nxt;
            o_busy       <= (state_nxt != IDLE);
        end
    end
endmodule
